// File: rtl/led_fader.sv
// led_fader: turns the hard on/off LED level from blinky into a PWM drive whose
// duty ramps linearly between 0 and MAX, so each transition fades.
//
// Parameters:
//   PwmBits    - duty resolution in bits (>= 2); MAX = 2^PwmBits-1
//   StepCycles - clock cycles per one-LSB duty step (>= 1)
//
// Ports:
//   clk_i   - system clock
//   rst_ni  - asynchronous active-low reset
//   led_i   - target LED level (same clock domain as blinky, no synchronizer)
//   led_o   - registered PWM LED drive
//   duty_o  - registered linear duty
//   busy_o  - high while rising or falling
//
// Build option:
//   LED_FADER_GAMMA_EN - when defined, the PWM compare value is
//   (duty*(duty+1)) >> PwmBits (gamma ~2); duty_o still reports the linear duty.

module led_fader #(
    parameter int unsigned PwmBits    = 8,
    parameter int unsigned StepCycles = 1000
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               led_i,
    output logic               led_o,
    output logic [PwmBits-1:0] duty_o,
    output logic               busy_o
);

    localparam int unsigned StepW = (StepCycles > 1) ? $clog2(StepCycles) : 1;
    localparam logic [PwmBits-1:0] DutyMax = '1;
    // Period counter stops one short of MAX so that duty MAX is a constant 1.
    localparam logic [PwmBits-1:0] CntLast = {{(PwmBits-1){1'b1}}, 1'b0};
    localparam logic [StepW-1:0]   StepLast = StepW'(StepCycles - 1);

    typedef enum logic [1:0] {
        StOff,
        StRise,
        StOn,
        StFall
    } state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic [PwmBits-1:0] r_duty;
    logic [PwmBits-1:0] w_duty_d;
    logic [StepW-1:0]   r_timer;
    logic [StepW-1:0]   w_timer_d;
    logic [PwmBits-1:0] r_cnt;
    logic               r_led;
    logic               r_busy;

    logic               w_step;
    logic [PwmBits-1:0] w_duty_inc;
    logic [PwmBits-1:0] w_duty_dec;
    logic [PwmBits-1:0] w_cmp;

    // ------------------------------------------------------------------
    // Compare value
    // ------------------------------------------------------------------
`ifdef LED_FADER_GAMMA_EN
    logic [2*PwmBits-1:0] w_duty_wide;
    logic [2*PwmBits-1:0] w_prod;

    assign w_duty_wide = {{PwmBits{1'b0}}, r_duty};
    // duty*(duty+1) keeps both endpoints exact: 0 -> 0, MAX -> MAX.
    assign w_prod      = w_duty_wide * (w_duty_wide + 1'b1);
    assign w_cmp       = PwmBits'(w_prod >> PwmBits);
`else
    assign w_cmp = r_duty;
`endif

    // ------------------------------------------------------------------
    // Free-running PWM period counter, never disturbed by state changes
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (r_cnt == CntLast) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Fade FSM: next state, duty and step timer
    // ------------------------------------------------------------------
    assign w_step     = (r_timer == StepLast);
    assign w_duty_inc = (r_duty == DutyMax) ? DutyMax : r_duty + 1'b1;
    assign w_duty_dec = (r_duty == '0) ? '0 : r_duty - 1'b1;

    always_comb begin
        w_state_d = r_state;
        w_duty_d  = r_duty;
        w_timer_d = '0;
        case (r_state)
            StOff: begin
                if (led_i) begin
                    w_state_d = StRise;
                end
            end
            StRise: begin
                // Reversal wins over a coincident step; the step is dropped.
                if (!led_i) begin
                    w_state_d = StFall;
                end else if (w_step) begin
                    w_duty_d = w_duty_inc;
                    if (w_duty_inc == DutyMax) begin
                        w_state_d = StOn;
                    end
                end else begin
                    w_timer_d = r_timer + 1'b1;
                end
            end
            StOn: begin
                if (!led_i) begin
                    w_state_d = StFall;
                end
            end
            StFall: begin
                if (led_i) begin
                    w_state_d = StRise;
                end else if (w_step) begin
                    w_duty_d = w_duty_dec;
                    if (w_duty_dec == '0) begin
                        w_state_d = StOff;
                    end
                end else begin
                    w_timer_d = r_timer + 1'b1;
                end
            end
            default: begin
                w_state_d = StOff;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StOff;
            r_duty  <= '0;
            r_timer <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_duty  <= w_duty_d;
            r_timer <= w_timer_d;
            r_busy  <= (w_state_d == StRise) || (w_state_d == StFall);
        end
    end

    // ------------------------------------------------------------------
    // PWM output; new duty takes effect immediately, mid-period
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_led <= 1'b0;
        end else begin
            r_led <= (r_cnt < w_cmp);
        end
    end

    assign led_o  = r_led;
    assign duty_o = r_duty;
    assign busy_o = r_busy;

endmodule

// File: tb/tb_led_fader.sv
module tb_led_fader;

    logic       clk_i;
    logic       rst_ni;
    logic       led_i;
    logic       led_o;
    logic [3:0] duty_o;
    logic       busy_o;

    logic       led2_i;
    logic       led2_o;
    logic [3:0] duty2_o;
    logic       busy2_o;

    int checks_q;
    int errors_q;

    led_fader #(
        .PwmBits    (4),
        .StepCycles (2)
    ) u_dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .led_i  (led_i),
        .led_o  (led_o),
        .duty_o (duty_o),
        .busy_o (busy_o)
    );

    // Slow-step instance for the steady-duty PWM count.
    led_fader #(
        .PwmBits    (4),
        .StepCycles (1000)
    ) u_dut_slow (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .led_i  (led2_i),
        .led_o  (led2_o),
        .duty_o (duty2_o),
        .busy_o (busy2_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_q++;
        if (obs !== exp) begin
            errors_q++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clock edges and land 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        int cnt;
        int xcnt;
        bit found;

        checks_q = 0;
        errors_q = 0;
        led_i    = 1'b0;
        led2_i   = 1'b0;
        rst_ni   = 1'b1;
        #1 rst_ni = 1'b0;
        #2;
        check("rst_led", 32'(led_o), 0);
        check("rst_duty", 32'(duty_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        tick(2);
        rst_ni = 1'b1;
        tick(3);
        check("idle_duty", 32'(duty_o), 0);
        check("idle_busy", 32'(busy_o), 0);

        // 1: rise to ON
        led_i = 1'b1;
        tick(1);
        check("rise_busy", 32'(busy_o), 1);
        check("rise_duty0", 32'(duty_o), 0);
        tick(1);
        check("rise_first_step_latency", 32'(duty_o), 0);
        tick(1);
        check("rise_duty1", 32'(duty_o), 1);
        tick(27);
        check("rise_duty14", 32'(duty_o), 14);
        check("rise_busy_late", 32'(busy_o), 1);
        tick(1);
        check("on_duty15", 32'(duty_o), 15);
        check("on_busy", 32'(busy_o), 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (led_o === 1'b1) cnt++;
        end
        check("on_led_const1", 32'(cnt), 20);

        // 2: fall to OFF
        led_i = 1'b0;
        tick(1);
        check("fall_busy", 32'(busy_o), 1);
        check("fall_duty15", 32'(duty_o), 15);
        tick(2);
        check("fall_duty14", 32'(duty_o), 14);
        tick(27);
        check("fall_duty1", 32'(duty_o), 1);
        tick(1);
        check("off_duty0", 32'(duty_o), 0);
        check("off_busy", 32'(busy_o), 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (led_o !== 1'b0) cnt++;
        end
        check("off_led_const0", 32'(cnt), 0);

        // 3: mid-rise reversal at duty 6
        led_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick(1);
            if (duty_o == 4'd6) found = 1'b1;
        end
        check("reach_duty6", 32'(found), 1);
        led_i = 1'b0;
        tick(1);
        check("rev_fall_busy", 32'(busy_o), 1);
        check("rev_no_jump", 32'(duty_o), 6);
        tick(1);
        check("rev_hold", 32'(duty_o), 6);
        tick(1);
        check("rev_duty5", 32'(duty_o), 5);
        // Reverse again exactly on the cycle a step would land: step is dropped.
        tick(1);
        led_i = 1'b1;
        tick(1);
        check("rev_prio_duty", 32'(duty_o), 5);
        check("rev_prio_busy", 32'(busy_o), 1);
        tick(2);
        check("rev_prio_rise", 32'(duty_o), 6);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick(1);
            if (busy_o == 1'b0) found = 1'b0 | 1'b1;
        end
        check("reach_on", 32'(found), 1);
        check("reach_on_duty", 32'(duty_o), 15);

        // 5: reset mid-fall
        tick(2);
        led_i = 1'b0;
        tick(10);
        check("midfall_duty", 32'(duty_o), 11);
        #2 rst_ni = 1'b0;
        #1;
        check("async_rst_led", 32'(led_o), 0);
        check("async_rst_duty", 32'(duty_o), 0);
        check("async_rst_busy", 32'(busy_o), 0);
        tick(2);
        rst_ni = 1'b1;
        tick(5);
        check("post_rst_busy", 32'(busy_o), 0);
        check("post_rst_duty", 32'(duty_o), 0);

        // 6: blinky-like square wave, 40-cycle halves
        xcnt = 0;
        for (int c = 0; c < 4; c++) begin
            led_i = 1'b1;
            for (int i = 0; i < 40; i++) begin
                tick(1);
                if ($isunknown(led_o)) xcnt++;
            end
            check("blinky_on_duty", 32'(duty_o), 15);
            led_i = 1'b0;
            for (int i = 0; i < 40; i++) begin
                tick(1);
                if ($isunknown(led_o)) xcnt++;
            end
            check("blinky_off_duty", 32'(duty_o), 0);
        end
        check("blinky_led_no_x", 32'(xcnt), 0);

        // 4: steady duty 5 on the slow instance, count highs over one period
        led2_i = 1'b1;
        tick(5200);
        check("slow_duty5", 32'(duty2_o), 5);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (led2_o === 1'b1) cnt++;
        end
`ifdef LED_FADER_GAMMA_EN
        check("slow_pwm_highs", 32'(cnt), 1);
`else
        check("slow_pwm_highs", 32'(cnt), 5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks_q, errors_q);
        $finish;
    end

endmodule
